// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter and burst sequencer for one shared single-port ROM with
// a one-cycle read latency. Read data returns with valid/last/id tags.
module rom_read_arbiter #(
  parameter int unsigned nreq        = 2,
  parameter int unsigned abits       = 12,
  parameter int unsigned log2_dbytes = 3,
  parameter int unsigned lenbits     = 8,
  localparam int unsigned dbits      = 8 << log2_dbytes,
  localparam int unsigned idw        = (nreq > 1) ? $clog2(nreq) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [nreq-1:0]          i_req_valid,
  input  logic [nreq*abits-1:0]    i_req_addr,
  input  logic [nreq*lenbits-1:0]  i_req_len,
  output logic [nreq-1:0]          o_req_ready,
  output logic [abits-1:0]         o_rom_addr,
  input  logic [dbits-1:0]         i_rom_data,
  output logic [nreq-1:0]          o_resp_valid,
  output logic [dbits-1:0]         o_resp_rdata,
  output logic                     o_resp_last,
  output logic [idw-1:0]           o_resp_id,
  output logic                     o_busy
);

  localparam int unsigned dbytes = 1 << log2_dbytes;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             state;
  logic [idw-1:0]     last_grant;
  logic [idw-1:0]     cur_id;
  logic [lenbits-1:0] cnt;

  logic [idw-1:0]     grant_id;
  logic               found;
  int unsigned        k;
  logic               accept;
  logic [abits-1:0]   sel_addr;
  logic [lenbits-1:0] sel_len;

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    o_req_ready = '0;
    grant_id    = '0;
    found       = 1'b0;
    k           = 0;
    if (state == S_IDLE) begin
      for (int i = 1; i <= int'(nreq); i++) begin
        k = (int'(last_grant) + i) % nreq;
        if (!found && i_req_valid[k]) begin
          found          = 1'b1;
          o_req_ready[k] = 1'b1;
          grant_id       = idw'(k);
        end
      end
    end
  end

  assign accept   = |(o_req_ready & i_req_valid);
  assign sel_addr = i_req_addr[int'(grant_id)*abits +: abits];
  assign sel_len  = i_req_len[int'(grant_id)*lenbits +: lenbits];

  // Read data bypasses a register so the response lines up with the ROM latency.
  assign o_resp_rdata = i_rom_data;
  assign o_busy       = (state == S_BURST) | (|o_resp_valid);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      last_grant   <= idw'(nreq - 1);
      cur_id       <= '0;
      cnt          <= '0;
      o_rom_addr   <= '0;
      o_resp_valid <= '0;
      o_resp_last  <= 1'b0;
      o_resp_id    <= '0;
    end else begin
      o_resp_valid <= '0;
      o_resp_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_BURST;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            o_rom_addr <= sel_addr & ~abits'(dbytes - 1);
            cnt        <= sel_len;
          end
        end
        S_BURST: begin
          // Tag the beat on o_rom_addr now; its data arrives next cycle.
          o_resp_valid <= nreq'(1) << cur_id;
          o_resp_last  <= (cnt == '0);
          o_resp_id    <= cur_id;
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            o_rom_addr <= o_rom_addr + abits'(dbytes);
            cnt        <= cnt - lenbits'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed self-checking bench for rom_read_arbiter (2 requesters, 12-bit
// address, 64-bit data) with a behavioural one-cycle-latency ROM.
module tb_rom_read_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic [1:0]  req_valid;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic [1:0]  req_ready;
  logic [11:0] rom_addr;
  logic [63:0] rom_q;
  logic [1:0]  resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_last;
  logic [0:0]  resp_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  rom_read_arbiter #(.nreq(2), .abits(12), .log2_dbytes(3), .lenbits(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .i_req_len    (req_len),
    .o_req_ready  (req_ready),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_q),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_last  (resp_last),
    .o_resp_id    (resp_id),
    .o_busy       (busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] romf(input logic [11:0] a);
    if (a == 12'h010) return 64'hA5A5_A5A5_A5A5_A5A5;
    return {16'hD00D, 36'h0, a};
  endfunction

  always @(posedge i_clk) rom_q <= romf(rom_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  task automatic set_req(input int r, input logic [11:0] a, input logic [7:0] l);
    req_addr[r*12 +: 12] = a;
    req_len[r*8 +: 8]    = l;
  endtask

  logic [11:0] wrap_addr [3];
  logic [1:0]  exp_v;
  int          addr_err, rdy_err, nresp, last_at, stray, bad1, n0;
  logic [63:0] last_data;

  initial begin
    wrap_addr = '{12'hFF0, 12'hFF8, 12'h000};
    i_rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Reset state
    mid();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_last", 64'(resp_last), 64'd0);
    check("rst_id", 64'(resp_id), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Single beat from requester 0
    nxt(); set_req(0, 12'h010, 8'd0); req_valid = 2'b01;
    mid(); check("t1_ready", 64'(req_ready), 64'h1);
    nxt(); req_valid = '0;
    mid(); check("t1_addr", 64'(rom_addr), 64'h010);
    check("t1_busy", 64'(busy), 64'd1);
    nxt();
    mid(); check("t1_rvalid", 64'(resp_valid), 64'h1);
    check("t1_last", 64'(resp_last), 64'd1);
    check("t1_rdata", resp_rdata, 64'hA5A5_A5A5_A5A5_A5A5);
    check("t1_id", 64'(resp_id), 64'd0);
    nxt();
    mid(); check("t1_idle_busy", 64'(busy), 64'd0);

    // Unaligned start, three beats wrapping the address space
    nxt(); set_req(1, 12'hFF3, 8'd2); req_valid = 2'b10;
    mid(); check("t2_ready", 64'(req_ready), 64'h2);
    nxt(); req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      mid();
      if (c <= 3) check("t2_addr", 64'(rom_addr), 64'(wrap_addr[c-1]));
      if (c >= 2) begin
        check("t2_rvalid", 64'(resp_valid), 64'h2);
        check("t2_id", 64'(resp_id), 64'd1);
        check("t2_rdata", resp_rdata, romf(wrap_addr[c-2]));
        check("t2_last", 64'(resp_last), 64'(c == 4));
      end
      nxt();
    end
    mid(); check("t2_idle_busy", 64'(busy), 64'd0);

    // Both requesters held valid: strict alternation, one accept per two cycles
    nxt(); set_req(0, 12'h100, 8'd0); set_req(1, 12'h200, 8'd0); req_valid = 2'b11;
    for (int c = 0; c < 40; c++) begin
      mid();
      exp_v = (c % 2 == 0) ? (((c / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check("t3_ready", 64'(req_ready), 64'(exp_v));
      exp_v = (c >= 2 && c % 2 == 0) ? ((((c / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check("t3_rvalid", 64'(resp_valid), 64'(exp_v));
      nxt();
    end
    req_valid = '0;
    mid(); check("t3_final_resp", 64'(resp_valid), 64'h2);
    check("t3_final_ready", 64'(req_ready), 64'd0);

    // Reset during the third issue cycle of an 8-beat burst
    nxt(); set_req(0, 12'h040, 8'd7); req_valid = 2'b01;
    mid(); check("t4_ready", 64'(req_ready), 64'h1);
    nxt(); req_valid = '0;
    mid(); check("t4_addr0", 64'(rom_addr), 64'h040);
    nxt();
    mid(); check("t4_addr1", 64'(rom_addr), 64'h048);
    nxt(); i_rst = 1'b1;
    mid(); check("t4_addr2", 64'(rom_addr), 64'h050);
    nxt(); i_rst = 1'b0;
    mid();
    check("t4_ready0", 64'(req_ready), 64'd0);
    check("t4_rvalid0", 64'(resp_valid), 64'd0);
    check("t4_last0", 64'(resp_last), 64'd0);
    check("t4_id0", 64'(resp_id), 64'd0);
    check("t4_addr_rst", 64'(rom_addr), 64'd0);
    check("t4_busy0", 64'(busy), 64'd0);
    nxt();
    mid(); check("t4_rvalid1", 64'(resp_valid), 64'd0);
    check("t4_busy1", 64'(busy), 64'd0);
    nxt(); set_req(0, 12'h040, 8'd0); set_req(1, 12'h300, 8'd0); req_valid = 2'b11;
    mid(); check("t4_prio0", 64'(req_ready), 64'h1);
    nxt(); req_valid = 2'b10;
    mid(); check("t4_burst_ready", 64'(req_ready), 64'd0);
    nxt();
    mid(); check("t4_then1", 64'(req_ready), 64'h2);
    check("t4_resp0", 64'(resp_valid), 64'h1);
    nxt(); req_valid = '0;
    mid(); nxt();
    mid(); check("t4_resp1", 64'(resp_valid), 64'h2);
    check("t4_resp1_id", 64'(resp_id), 64'd1);
    nxt();

    // Maximum burst length, with requester 1 pending throughout
    set_req(0, 12'h000, 8'd255); req_valid = 2'b01;
    mid(); check("t5_ready", 64'(req_ready), 64'h1);
    nxt(); req_valid = 2'b10;
    addr_err = 0; rdy_err = 0; nresp = 0; last_at = 0; stray = 0; last_data = '0;
    for (int c = 1; c <= 257; c++) begin
      mid();
      if (c <= 256) begin
        if (rom_addr !== 12'((c - 1) * 8)) addr_err++;
        if (req_ready !== 2'b00) rdy_err++;
      end else begin
        check("t5_next_grant", 64'(req_ready), 64'h2);
      end
      if (resp_valid === 2'b01) begin
        nresp++;
        if (resp_last) begin
          last_at   = nresp;
          last_data = resp_rdata;
        end
      end
      if (resp_valid[1]) stray++;
      nxt();
    end
    req_valid = '0;
    check("t5_addr_seq_errs", 64'(addr_err), 64'd0);
    check("t5_ready_in_burst", 64'(rdy_err), 64'd0);
    check("t5_nresp", 64'(nresp), 64'd256);
    check("t5_last_at", 64'(last_at), 64'd256);
    check("t5_last_data", last_data, romf(12'h7F8));
    check("t5_stray1", 64'(stray), 64'd0);
    mid(); check("t5_req1_addr", 64'(rom_addr), 64'h300);
    nxt();
    mid(); check("t5_req1_resp", 64'(resp_valid), 64'h2);
    check("t5_req1_last", 64'(resp_last), 64'd1);
    nxt();

    // Requester 1 valid only while a burst is running: never granted
    set_req(0, 12'h080, 8'd3);
    bad1 = 0; n0 = 0;
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c == 0) ? 2'b01 : ((c == 2 || c == 3) ? 2'b10 : 2'b00);
      mid();
      if (c == 0) check("t6_ready0", 64'(req_ready), 64'h1);
      if (req_ready[1] || resp_valid[1]) bad1++;
      if (resp_valid[0]) n0++;
      nxt();
    end
    check("t6_no_req1", 64'(bad1), 64'd0);
    check("t6_req0_beats", 64'(n0), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Round-robin arbiter and burst sequencer sharing one synchronous single-port ROM (rom_tech instance, 1-cycle read latency) between nreq requesters, e.g. the ROM AXI slave path and a boot/debug fetch path.
- Grants one requester at a time and issues that requester's burst as incrementing, bus-aligned ROM addresses, one per cycle.
- Returns read data to the granted requester with valid/last/id tags.

Parameters:
- nreq, 2, number of requesters (2..8).
- abits, 12, ROM byte-address width.
- log2_dbytes, 3, log2 of ROM data bytes; data width dbits = 8 << log2_dbytes.
- lenbits, 8, burst length field width (encodes beats-1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  nreq  per-requester request valid.
- i_req_addr  in  nreq*abits  packed start byte addresses; requester k uses bits [k*abits +: abits].
- i_req_len  in  nreq*lenbits  packed burst lengths, beats-1.
- o_req_ready  out  nreq  one-hot accept strobe.
- o_rom_addr  out  abits  byte address to ROM.
- i_rom_data  in  dbits  ROM read data, valid 1 cycle after address.
- o_resp_valid  out  nreq  one-hot response valid.
- o_resp_rdata  out  dbits  response data, shared by all requesters.
- o_resp_last  out  1  final beat of the burst.
- o_resp_id  out  $clog2(nreq) (min 1)  requester index of the response.
- o_busy  out  1  burst in progress or response pending.

Behaviour:
- Reset (i_rst=1 at rising edge):
  - state=IDLE; o_req_ready=0, o_resp_valid=0, o_resp_last=0, o_resp_id=0, o_rom_addr=0, o_busy=0.
  - Round-robin pointer last_grant=nreq-1, so requester 0 has priority after reset.
  - Any in-flight beat or pending response is discarded; no response appears after reset.
- FSM states: IDLE, BURST.
- IDLE:
  - o_req_ready is combinational: one-hot for the first valid requester searching last_grant+1, last_grant+2, ... modulo nreq. Zero if none is valid.
  - Handshake completes when valid & ready are both high in the same cycle. On accept, latch:
    - id
    - addr = i_req_addr with low log2_dbytes bits forced to 0
    - cnt = i_req_len
  - On accept, set last_grant=id and go to BURST.
- BURST:
  - Each cycle, o_rom_addr=addr; beat issued.
  - Next address: addr += 2^log2_dbytes, modulo 2^abits (wraps 0x..FF8 -> 0x000 for 64-bit data).
  - cnt decrements. The beat issued with cnt==0 is last; state then returns to IDLE.
  - o_req_ready=0 throughout BURST.
- Response pipe: one cycle after each issued beat:
  - o_resp_valid[id]=1 for exactly one cycle.
  - o_resp_rdata=i_rom_data, o_resp_id=id.
  - o_resp_last=1 only for the last beat.
  - No backpressure; consumers must accept every beat.
- Latency and throughput:
  - Accept at cycle T, first address at T+1, first response at T+2.
  - Burst of N beats: responses at T+2..T+N+1. Next accept possible at T+N+1.
  - One dead issue cycle between bursts.
- o_rom_addr holds its last value in IDLE.
- o_busy = (state==BURST) | response pipe valid.
- Simultaneous valid from all requesters: strict rotation; no requester is granted twice while another is waiting.
- i_req_valid deasserted in the same cycle ready rises: no accept (handshake needs both).
- Requester inputs are ignored outside the accept cycle. Changing addr or len mid-burst has no effect.
- len = 2^lenbits-1 (256 beats) is legal. The counter never underflows past the last beat.

Test Plan:
- Reset then single request: req0 addr=0x010, len=0, ROM word at 0x010 = 0xA5A5...
  - ready0 in cycle 0; o_rom_addr=0x010 at cycle 1.
  - resp_valid=2'b01, last=1, rdata=0xA5A5..., id=0 at cycle 2.
  - o_busy low at cycle 3.
- Burst with wrap: req1 addr=0xFF3 (abits=12, 64-bit), len=2.
  - o_rom_addr sequence 0xFF0, 0xFF8, 0x000.
  - 3 responses with id=1; last only on the third.
- Contention: req0 and req1 both held valid continuously, len=0.
  - Grants alternate 0,1,0,1; accepts every 2 cycles; no starvation over 20 bursts.
- Reset mid-burst: req0 len=7 accepted; i_rst asserted on the 3rd issue cycle.
  - Next cycle all outputs 0, state IDLE, no further resp_valid.
  - req1 and req0 then both valid -> req0 granted first.
- Max length: len=255 from addr=0.
  - Exactly 256 responses; last on the 256th (address 0x7F8).
  - Immediately after, a pending req1 is granted.
- Late drop: req1 valid only in a cycle where state=BURST, deasserted before IDLE.
  - Never granted; no response with id=1.
